// File: rtl/ins_cache_controller.sv
// ins_cache_controller
//   Direct-mapped instruction cache with a block-fill controller, sitting between
//   the CPU fetch stage and the instruction memory. Lines are 16 bytes. Hits return
//   the instruction word combinationally. A miss stalls the CPU through BUSYWAIT
//   while a block is read over the READ/BUSYWAIT handshake, then the line is filled.
//
// Ports
//   CLK           in   1    system clock, posedge
//   RESET         in   1    synchronous, active-high reset
//   READ          in   1    CPU fetch request
//   ADDRESS       in   32   CPU byte address (PC); bits [1:0] ignored
//   INSTRUCTION   out  32   fetched word, 0 when idle or on a miss
//   BUSYWAIT      out  1    stall to CPU
//   MEM_READ      out  1    block read request to instruction memory
//   MEM_ADDRESS   out  28   block address (registered at miss time)
//   MEM_READDATA  in   128  block from memory, byte 0 in [7:0]
//   MEM_BUSYWAIT  in   1    memory busy; falls when MEM_READDATA is valid
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | serving hits; a miss latches the block address and requests it
// S_MEM_READ | MEM_READ high, waiting for memory to drop MEM_BUSYWAIT
// S_UPDATE   | write the returned block, tag and valid into the line

module ins_cache_controller #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 25    // must equal 28 - INDEX_BITS
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic [31:0]  ADDRESS,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_store  [LINES];
    logic [127:0]        data_store [LINES];

    logic [TAG_BITS-1:0]   addr_tag;
    logic [INDEX_BITS-1:0] addr_index;
    logic [1:0]            addr_word;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [127:0]          line_data;
    logic                  hit;
    logic                  unused_addr_bits;

    assign addr_tag   = ADDRESS[31:4+INDEX_BITS];
    assign addr_index = ADDRESS[4+INDEX_BITS-1:4];
    assign addr_word  = ADDRESS[3:2];
    // Byte offset within the word is deliberately ignored (no misalignment trap).
    assign unused_addr_bits = ^ADDRESS[1:0];

    // The fill targets the registered block address, so a CPU that changes
    // ADDRESS mid-stall cannot redirect the write to another line.
    assign fill_index = MEM_ADDRESS[INDEX_BITS-1:0];
    assign fill_tag   = MEM_ADDRESS[27:INDEX_BITS];

    assign hit       = READ & valid[addr_index] & (tag_store[addr_index] == addr_tag);
    assign line_data = data_store[addr_index];

    always_comb begin
        INSTRUCTION = 32'h0;
        if (hit && !RESET) begin
            case (addr_word)
                2'd0:    INSTRUCTION = line_data[31:0];
                2'd1:    INSTRUCTION = line_data[63:32];
                2'd2:    INSTRUCTION = line_data[95:64];
                default: INSTRUCTION = line_data[127:96];
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        BUSYWAIT  = 1'b0;
        MEM_READ  = 1'b0;
        case (state)
            S_IDLE: begin
                BUSYWAIT = READ & ~hit;
                if (READ && !hit) state_nxt = S_MEM_READ;
            end
            S_MEM_READ: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                BUSYWAIT  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (RESET) BUSYWAIT = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            valid       <= '0;
            MEM_ADDRESS <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && READ && !hit) MEM_ADDRESS <= ADDRESS[31:4];
            if (state == S_UPDATE) valid[fill_index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        if (!RESET && state == S_UPDATE) begin
            data_store[fill_index] <= MEM_READDATA;
            tag_store[fill_index]  <= fill_tag;
        end
    end

endmodule

// File: tb/tb_ins_cache_controller.sv
// tb_ins_cache_controller
//   Directed bench for ins_cache_controller with a behavioural instruction memory.
//   The memory raises MEM_BUSYWAIT just after it sees MEM_READ, holds it for
//   mem_busy_n sampling edges, then drops it and presents the block.

module tb_ins_cache_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic         read;
    logic [31:0]  address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int n_checks = 0;
    int n_pass   = 0;
    int req_count = 0;
    int mem_busy_n = 3;

    always #5 clk = ~clk;

    ins_cache_controller #(.INDEX_BITS(3), .TAG_BITS(25)) dut (
        .CLK          (clk),
        .RESET        (reset),
        .READ         (read),
        .ADDRESS      (address),
        .INSTRUCTION  (instruction),
        .BUSYWAIT     (busywait),
        .MEM_READ     (mem_read),
        .MEM_ADDRESS  (mem_address),
        .MEM_READDATA (mem_readdata),
        .MEM_BUSYWAIT (mem_busywait)
    );

    // Memory contents: one arbitrary word per word address.
    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        logic [31:0] w;
        w = {2'b00, wa} * 32'h0101_0101;
        return w ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] b);
        logic [127:0] blk;
        logic [1:0]   wsel;
        blk = '0;
        for (int i = 0; i < 4; i++) begin
            wsel = i[1:0];
            blk[32*i +: 32] = mem_word({b, wsel});
        end
        return blk;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory model
    initial begin
        logic        armed;
        logic        active;
        int          busy_left;
        logic [27:0] req_addr;
        armed        = 1'b1;
        active       = 1'b0;
        busy_left    = 0;
        req_addr     = '0;
        mem_busywait = 1'b0;
        mem_readdata = {4{32'hDEAD_BEEF}};
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_busywait = 1'b0;
                active       = 1'b0;
                armed        = 1'b1;
            end else if (active) begin
                if (busy_left > 1) busy_left--;
                else begin
                    mem_busywait = 1'b0;
                    mem_readdata = mem_block(req_addr);
                    active       = 1'b0;
                end
            end else if (mem_read && armed) begin
                mem_busywait = 1'b1;
                mem_readdata = {4{32'hDEAD_BEEF}};
                busy_left    = mem_busy_n;
                req_addr     = mem_address;
                active       = 1'b1;
                armed        = 1'b0;
                req_count++;
            end else if (!mem_read) begin
                armed = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge in IDLE; runs a full miss and fill for address a.
    task automatic fetch_miss(input logic [31:0] a, input int n);
        int req0;
        int stall;
        int rd_cycles;
        mem_busy_n = n;
        req0       = req_count;
        read       = 1'b1;
        address    = a;
        #1;
        check("miss_busywait", {31'b0, busywait}, 32'd1);
        check("miss_no_memread_yet", {31'b0, mem_read}, 32'd0);
        step();
        check("memread_entry", {31'b0, mem_read}, 32'd1);
        check("mem_address", {4'b0, mem_address}, {4'b0, a[31:4]});
        stall     = 0;
        rd_cycles = 0;
        while (busywait && stall < 100) begin
            if (mem_read) rd_cycles++;
            stall++;
            step();
        end
        check("stall_cycles", stall, n + 2);
        check("memread_cycles", rd_cycles, n + 1);
        check("mem_requests", req_count, req0 + 1);
        check("fill_instruction", instruction, mem_word(a[31:2]));
    endtask

    task automatic expect_hit(input logic [31:0] a);
        read    = 1'b1;
        address = a;
        #1;
        check("hit_busywait", {31'b0, busywait}, 32'd0);
        check("hit_instruction", instruction, mem_word(a[31:2]));
        check("hit_memread", {31'b0, mem_read}, 32'd0);
        step();
    endtask

    initial begin
        int req0;
        reset   = 1'b1;
        read    = 1'b1;
        address = 32'h0;
        step();
        step();
        check("rst_busywait", {31'b0, busywait}, 32'd0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_memread", {31'b0, mem_read}, 32'd0);
        check("rst_mem_address", {4'b0, mem_address}, 32'h0);
        reset = 1'b0;

        // Cold miss on block 0
        fetch_miss(32'h0000_0000, 3);

        // Hits on the remaining words; byte offset ignored
        expect_hit(32'h0000_0004);
        expect_hit(32'h0000_0008);
        expect_hit(32'h0000_000C);
        expect_hit(32'h0000_000F);

        // READ low: no stall, no request, zero output
        req0    = req_count;
        read    = 1'b0;
        address = 32'h0000_0080;
        #1;
        check("idle_busywait", {31'b0, busywait}, 32'd0);
        check("idle_instruction", instruction, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_memread", {31'b0, mem_read}, 32'd0);
        end
        address = 32'h0000_0000;
        #1;
        check("idle_valid_line_instruction", instruction, 32'h0);
        check("idle_no_request", req_count, req0);

        // Conflict on index 0: replace, then original misses again
        fetch_miss(32'h0000_0080, 3);
        expect_hit(32'h0000_0084);
        read    = 1'b1;
        address = 32'h0000_0000;
        #1;
        check("conflict_miss", {31'b0, busywait}, 32'd1);
        fetch_miss(32'h0000_0000, 3);

        // Reset in the middle of a fill
        mem_busy_n = 5;
        read       = 1'b1;
        address    = 32'h0000_0100;
        #1;
        step();
        check("pre_reset_memread", {31'b0, mem_read}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_held_busywait", {31'b0, busywait}, 32'd0);
        check("reset_held_instruction", instruction, 32'h0);
        step();
        check("post_reset_memread", {31'b0, mem_read}, 32'd0);
        check("post_reset_mem_address", {4'b0, mem_address}, 32'h0);
        reset = 1'b0;
        fetch_miss(32'h0000_0000, 3);

        // Memory latency extremes
        fetch_miss(32'h0000_0010, 1);
        fetch_miss(32'h0000_002C, 20);
        expect_hit(32'h0000_0020);

        read = 1'b0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
